// File: rtl/nn_pkg.sv
// Shared definitions for the input-RAM fetch path.
//   DATA_W        pixel / RAM word width
//   ADDR_W        input RAM address width (512 words)
//   CNT_W         width of the window/tap counters
//   fetch_state_t fetch sequencer states
package nn_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned CNT_W  = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/window_counter.sv
// Nested tap/window counters for the convolution window walk.
// Tap order kx (inner) then ky; window order ox (inner) then oy.
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   step             advance to the next tap
//   clear            return all counters to zero (wins over step)
//   tap_last         current tap is the last of its window
//   win_last         current tap is the last tap of the last window
//   in_bounds        current tap lies inside the image (always 1 without padding)
//   tap_offset       row-major word offset of the current tap, mod 512
module window_counter
  import nn_pkg::*;
#(
  parameter int unsigned IMG_W = 16,
  parameter int unsigned IMG_H = 16,
  parameter int unsigned KSIZE = 3,
  parameter int unsigned OUT_W = 14,
  parameter int unsigned OUT_H = 14,
  parameter int unsigned PAD   = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              step,
  input  logic              clear,
  output logic              tap_last,
  output logic              win_last,
  output logic              in_bounds,
  output logic [ADDR_W-1:0] tap_offset
);

  logic [CNT_W-1:0] kx_q, kx_d;
  logic [CNT_W-1:0] ky_q, ky_d;
  logic [CNT_W-1:0] ox_q, ox_d;
  logic [CNT_W-1:0] oy_q, oy_d;

  logic kx_wrap, ky_wrap, ox_wrap, oy_wrap;

  assign kx_wrap = (kx_q == CNT_W'(KSIZE - 1));
  assign ky_wrap = (ky_q == CNT_W'(KSIZE - 1));
  assign ox_wrap = (ox_q == CNT_W'(OUT_W - 1));
  assign oy_wrap = (oy_q == CNT_W'(OUT_H - 1));

  assign tap_last = kx_wrap && ky_wrap;
  assign win_last = tap_last && ox_wrap && oy_wrap;

  always_comb begin
    kx_d = kx_q;
    ky_d = ky_q;
    ox_d = ox_q;
    oy_d = oy_q;
    if (clear) begin
      kx_d = '0;
      ky_d = '0;
      ox_d = '0;
      oy_d = '0;
    end else if (step) begin
      if (!kx_wrap) begin
        kx_d = kx_q + CNT_W'(1);
      end else begin
        kx_d = '0;
        if (!ky_wrap) begin
          ky_d = ky_q + CNT_W'(1);
        end else begin
          ky_d = '0;
          if (!ox_wrap) begin
            ox_d = ox_q + CNT_W'(1);
          end else begin
            ox_d = '0;
            oy_d = oy_wrap ? '0 : oy_q + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      kx_q <= '0;
      ky_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
    end else begin
      kx_q <= kx_d;
      ky_q <= ky_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
    end
  end

  // Signed pixel coordinates so padded taps (negative or past the edge) are detectable.
  int tap_row, tap_col;

  assign tap_row = int'(oy_q) + int'(ky_q) - int'(PAD);
  assign tap_col = int'(ox_q) + int'(kx_q) - int'(PAD);

  assign in_bounds = (tap_row >= 0) && (tap_row < int'(IMG_H)) &&
                     (tap_col >= 0) && (tap_col < int'(IMG_W));

  assign tap_offset = ADDR_W'(tap_row * int'(IMG_W) + tap_col);

endmodule

// File: rtl/input_window_fetch.sv
// Walks every KSIZE x KSIZE window of an IMG_W x IMG_H image held row-major in the
// input RAM at BASE_ADDR and streams one pixel per beat over valid/ready.
// Build option: define INPUT_FETCH_PAD_EN for same-size output with zero padding
// (out-of-image taps emit 0 and do not enable the RAM).
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   start            one-cycle pulse, begins a pass when idle
//   busy             pass in progress (through the done cycle)
//   done             one-cycle pulse after the final beat is accepted
//   ram_address      input RAM read address (combinational from the counters)
//   ram_enable       RAM read in progress
//   ram_read_data    combinational RAM read data for ram_address
//   out_valid/ready  output handshake
//   out_data         pixel value
//   out_tap_last     last tap of a window
//   out_win_last     last tap of the last window
module input_window_fetch
  import nn_pkg::*;
#(
  parameter int unsigned IMG_W     = 16,
  parameter int unsigned IMG_H     = 16,
  parameter int unsigned KSIZE     = 3,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_enable,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_tap_last,
  output logic              out_win_last
);

`ifdef INPUT_FETCH_PAD_EN
  localparam int unsigned PAD   = (KSIZE - 1) / 2;
  localparam int unsigned OUT_W = IMG_W;
  localparam int unsigned OUT_H = IMG_H;
`else
  localparam int unsigned PAD   = 0;
  localparam int unsigned OUT_W = IMG_W - KSIZE + 1;
  localparam int unsigned OUT_H = IMG_H - KSIZE + 1;
`endif

  fetch_state_t      state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              tap_last_q, tap_last_d;
  logic              win_last_q, win_last_d;
  // Final tap has been captured; only its acceptance remains.
  logic              fetched_q, fetched_d;

  logic              cnt_step, cnt_clear;
  logic              tap_last, win_last, in_bounds;
  logic [ADDR_W-1:0] tap_offset;
  logic              advance;

  window_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .KSIZE (KSIZE),
    .OUT_W (OUT_W),
    .OUT_H (OUT_H),
    .PAD   (PAD)
  ) u_window_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .step       (cnt_step),
    .clear      (cnt_clear),
    .tap_last   (tap_last),
    .win_last   (win_last),
    .in_bounds  (in_bounds),
    .tap_offset (tap_offset)
  );

  assign advance = !valid_q || out_ready;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    data_d     = data_q;
    tap_last_d = tap_last_q;
    win_last_d = win_last_q;
    fetched_d  = fetched_q;
    cnt_step   = 1'b0;
    cnt_clear  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_clear = 1'b1;
        end
      end
      RUN: begin
        if (fetched_q) begin
          if (valid_q && out_ready) begin
            valid_d = 1'b0;
            state_d = DONE;
          end
        end else if (advance) begin
          valid_d    = 1'b1;
          data_d     = in_bounds ? ram_read_data : '0;
          tap_last_d = tap_last;
          win_last_d = win_last;
          fetched_d  = win_last;
          cnt_step   = 1'b1;
        end
      end
      DONE: begin
        state_d    = IDLE;
        fetched_d  = 1'b0;
        tap_last_d = 1'b0;
        win_last_d = 1'b0;
        cnt_clear  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      data_q     <= '0;
      tap_last_q <= 1'b0;
      win_last_q <= 1'b0;
      fetched_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      tap_last_q <= tap_last_d;
      win_last_q <= win_last_d;
      fetched_q  <= fetched_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign out_valid    = valid_q;
  assign out_data     = data_q;
  assign out_tap_last = tap_last_q;
  assign out_win_last = win_last_q;

  // Padded taps park the address at BASE_ADDR, which is also the reset address.
  assign ram_address = in_bounds ? ADDR_W'(BASE_ADDR) + tap_offset : ADDR_W'(BASE_ADDR);

`ifdef INPUT_FETCH_PAD_EN
  assign ram_enable = (state_q == RUN) && in_bounds;
`else
  assign ram_enable = (state_q == RUN);
`endif

endmodule

// File: tb/tb_input_window_fetch.sv
module tb_input_window_fetch;

  localparam int IMG_W   = 16;
  localparam int IMG_H   = 16;
  localparam int K       = 3;
  localparam int BASE    = 0;
  localparam int MAX_CYC = 6000;
`ifdef INPUT_FETCH_PAD_EN
  localparam int PAD      = 1;
  localparam int OUT_W    = 16;
  localparam int OUT_H    = 16;
  localparam int TOTAL    = 2304;
  localparam int LAST_VAL = 0;
  int first_tbl [12] = '{0, 0, 0, 0, 0, 1, 0, 16, 17, 0, 0, 0};
`else
  localparam int PAD      = 0;
  localparam int OUT_W    = 14;
  localparam int OUT_H    = 14;
  localparam int TOTAL    = 1764;
  localparam int LAST_VAL = 255;
  int first_tbl [12] = '{0, 1, 2, 16, 17, 18, 32, 33, 34, 1, 2, 3};
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [8:0]  ram_address;
  logic        ram_enable;
  logic [15:0] ram_read_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_tap_last;
  logic        out_win_last;

  logic [15:0] mem [512];

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clock = ~clock;

  assign ram_read_data = mem[ram_address];

  input_window_fetch #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .KSIZE     (K),
    .BASE_ADDR (BASE)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .ram_address   (ram_address),
    .ram_enable    (ram_enable),
    .ram_read_data (ram_read_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_tap_last  (out_tap_last),
    .out_win_last  (out_win_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference for tap number idx of a pass, derived from the window walk order.
  task automatic exp_tap(input int idx, output int val, output int addr, output bit inb);
    int win, tap, ox, oy, kx, ky, r, c;
    win  = idx / (K * K);
    tap  = idx % (K * K);
    ox   = win % OUT_W;
    oy   = win / OUT_W;
    ky   = tap / K;
    kx   = tap % K;
    r    = oy + ky - PAD;
    c    = ox + kx - PAD;
    inb  = (r >= 0) && (r < IMG_H) && (c >= 0) && (c < IMG_W);
    addr = inb ? (BASE + r * IMG_W + c) % 512 : BASE;
    val  = inb ? int'(mem[addr]) : 0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_valid"}, out_valid, 0);
    check({pfx, "_tap_last"}, out_tap_last, 0);
    check({pfx, "_win_last"}, out_win_last, 0);
    check({pfx, "_data"}, out_data, 0);
    check({pfx, "_ram_en"}, ram_enable, 0);
    check({pfx, "_ram_addr"}, ram_address, BASE);
  endtask

  // One pass with optional stall at a beat, stray start at a beat, or reset at a beat.
  task automatic run_pass(input int stall_beat, input int restart_beat, input int reset_beat);
    int beats, cyc, done_cnt, done_cyc, last_cyc, stall_cnt, cap, v, a;
    int data_errs, flag_errs, ram_errs;
    bit inb, finished;
    beats = 0; cyc = 0; done_cnt = 0; done_cyc = -1; last_cyc = -10; stall_cnt = 0;
    data_errs = 0; flag_errs = 0; ram_errs = 0; finished = 0;

    @(negedge clock);
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("no_valid_yet", out_valid, 0);

    while (!finished && cyc < MAX_CYC) begin
      out_ready = 1'b1;
      if (beats == stall_beat && out_valid && stall_cnt < 5) begin
        out_ready = 1'b0;
        stall_cnt++;
      end
      start = (beats == restart_beat);

      if (beats == reset_beat) begin
        reset_n = 1'b0;
        start   = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clock);
        check("rst_no_done", done, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_idle_busy", busy, 0);
        check("rst_idle_valid", out_valid, 0);
        return;
      end

      if (done_cnt > 0 && !done) begin
        finished = 1'b1;
        check("busy_fall", busy, 0);
      end else begin
        cap = beats + (out_valid ? 1 : 0);
        if (busy && !done && cap < TOTAL) begin
          exp_tap(cap, v, a, inb);
          if (ram_address !== 9'(a)) ram_errs++;
          if (ram_enable !== inb) ram_errs++;
        end
        if (out_valid && !out_ready) begin
          exp_tap(beats, v, a, inb);
          check("stall_data", out_data, v);
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (out_valid && out_ready) begin
          exp_tap(beats, v, a, inb);
          if (beats < 12) check($sformatf("beat%0d", beats), out_data, first_tbl[beats]);
          if (beats == 8) check("tap_last_first", out_tap_last, 1);
          if (out_data !== 16'(v)) data_errs++;
          if (out_tap_last !== (beats % (K * K) == K * K - 1)) flag_errs++;
          if (out_win_last !== (beats == TOTAL - 1)) flag_errs++;
          if (beats == TOTAL - 1) begin
            check("last_value", out_data, LAST_VAL);
            check("last_win", out_win_last, 1);
            last_cyc = cyc;
          end
          beats++;
        end
      end
      cyc++;
      @(negedge clock);
    end
    start = 1'b0;

    check("pass_finished", finished, 1);
    check("beats_total", beats, TOTAL);
    check("done_pulses", done_cnt, 1);
    check("done_latency", done_cyc, last_cyc + 1);
    check("stream_data_errs", data_errs, 0);
    check("stream_flag_errs", flag_errs, 0);
    check("ram_errs", ram_errs, 0);
    if (stall_beat >= 0) check("stall_cycles", stall_cnt, 5);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'(i);
    reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_busy", busy, 0);

    run_pass(-1, -1, -1);   // plain full pass
    run_pass(3, 50, -1);    // stall on beat value 16, stray start mid-pass
    run_pass(-1, -1, 100);  // reset mid-pass
    run_pass(-1, -1, -1);   // restart after reset begins at value 0

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
